// File: rtl/station_tracker.sv
// station_tracker: follows barcode station IDs toward a commanded destination.
// Accepts go/stop commands, drives go while navigating, and acknowledges every
// reader ID with a one-cycle clr_ID_vld pulse. It also counts the intermediate
// stations passed and raises a sticky timeout when stations stop arriving.
//
// Optional build macro DUP_FILTER_EN: when it is defined, a valid non-matching
// ID equal to last_ID is treated as a re-read of the same station. That ID is
// still acknowledged, but it does not advance stn_cnt or restart the timer.
//
// Handshakes: ID_vld and cmd_rdy are levels held by the producer until they are
// acknowledged. clr_ID_vld and clr_cmd_rdy are registered single-cycle pulses.
// After a pulse, the producer must drop its level before the same channel is
// acknowledged again.
//
// state_dbg exposes the FSM state (0=IDLE, 1=NAV, 2=ACK) for observation.
module station_tracker #(
  parameter int unsigned        TMO_W   = 24,
  parameter logic [TMO_W-1:0]   TMO_CYC = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  output logic       go,
  output logic       arrived,
  output logic       tmo,
  output logic [3:0] stn_cnt,
  output logic [5:0] last_ID,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NAV  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_STOP = 2'b00;
  localparam logic [1:0]       OP_GO   = 2'b01;
  localparam logic [TMO_W-1:0] TMR_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMR_END = TMO_CYC - TMR_ONE;

  state_t           state_q, state_d;
  logic [5:0]       dest_q, dest_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             cmd_busy_q, cmd_busy_d;
  logic             match_q, match_d;
  logic             go_d, arrived_d, tmo_d, clr_id_d, clr_cmd_d;
  logic [3:0]       cnt_d;
  logic [5:0]       last_d;

  logic             cmd_take;
  logic             id_valid;
  logic             id_match;
  logic             id_dup;

  // A command is taken once per cmd_rdy assertion.
  assign cmd_take = cmd_rdy && !cmd_busy_q;
  assign id_valid = (ID[7:6] == 2'b00);
  assign id_match = (ID[5:0] == dest_q);

`ifdef DUP_FILTER_EN
  assign id_dup = (ID[5:0] == last_ID);
`else
  assign id_dup = 1'b0;
`endif

  assign state_dbg = state_q;

  // State and output registers. Reset clears everything, so no pulse can leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dest_q      <= 6'd0;
      timer_q     <= '0;
      cmd_busy_q  <= 1'b0;
      match_q     <= 1'b0;
      go          <= 1'b0;
      arrived     <= 1'b0;
      tmo         <= 1'b0;
      clr_ID_vld  <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      stn_cnt     <= 4'd0;
      last_ID     <= 6'd0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      timer_q     <= timer_d;
      cmd_busy_q  <= cmd_busy_d;
      match_q     <= match_d;
      go          <= go_d;
      arrived     <= arrived_d;
      tmo         <= tmo_d;
      clr_ID_vld  <= clr_id_d;
      clr_cmd_rdy <= clr_cmd_d;
      stn_cnt     <= cnt_d;
      last_ID     <= last_d;
    end
  end

  // Next-state and next-output logic. Pulses default low; other values hold.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    timer_d    = timer_q;
    match_d    = match_q;
    go_d       = go;
    arrived_d  = 1'b0;
    tmo_d      = tmo;
    clr_id_d   = 1'b0;
    clr_cmd_d  = 1'b0;
    cnt_d      = stn_cnt;
    last_d     = last_ID;
    // The busy flag is released as soon as the commander drops cmd_rdy.
    cmd_busy_d = cmd_rdy ? cmd_busy_q : 1'b0;

    unique case (state_q)
      S_IDLE: begin
        go_d = 1'b0;
        if (cmd_take) begin
          clr_cmd_d  = 1'b1;
          cmd_busy_d = 1'b1;
          if (cmd[7:6] == OP_GO) begin
            dest_d  = cmd[5:0];
            cnt_d   = 4'd0;
            tmo_d   = 1'b0;
            timer_d = '0;
            go_d    = 1'b1;
            state_d = S_NAV;
          end
        end else if (ID_vld) begin
          // The ID is acknowledged but does not count. ACK returns here.
          clr_id_d = 1'b1;
          match_d  = 1'b1;
          state_d  = S_ACK;
        end
      end

      S_NAV: begin
        if (cmd_take) begin
          // A command beats a pending ID. The ID stays high and is served later.
          clr_cmd_d  = 1'b1;
          cmd_busy_d = 1'b1;
          timer_d    = timer_q + TMR_ONE;
          if (cmd[7:6] == OP_STOP) begin
            go_d    = 1'b0;
            state_d = S_IDLE;
          end else if (cmd[7:6] == OP_GO) begin
            dest_d  = cmd[5:0];
            cnt_d   = 4'd0;
            timer_d = '0;
          end
        end else if (ID_vld) begin
          // An ID, even one arriving on the timeout cycle, wins over the timeout.
          clr_id_d = 1'b1;
          state_d  = S_ACK;
          timer_d  = timer_q + TMR_ONE;
          if (id_valid) begin
            last_d = ID[5:0];
            if (id_match) begin
              arrived_d = 1'b1;
              go_d      = 1'b0;
              match_d   = 1'b1;
              timer_d   = '0;
            end else if (!id_dup) begin
              timer_d = '0;
              if (stn_cnt != 4'hF) begin
                cnt_d = stn_cnt + 4'd1;
              end
            end
          end
        end else if (timer_q >= TMR_END) begin
          // Using >= makes the timeout fire even if an event skipped the exact count.
          tmo_d   = 1'b1;
          go_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      S_ACK: begin
        // The timer is frozen here, and any command waits until exit.
        if (!ID_vld) begin
          state_d = match_q ? S_IDLE : S_NAV;
          match_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_station_tracker.sv
// Bench for station_tracker: directed scenarios, then randomized reader and
// commander traffic. All of it is checked cycle by cycle against a reference
// model that tracks deadlines in absolute cycle numbers.
module tb_station_tracker;

  localparam int         TMO     = 100;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NAV  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic       go;
  logic       arrived;
  logic       tmo;
  logic [3:0] stn_cnt;
  logic [5:0] last_ID;
  logic [1:0] state_dbg;

  station_tracker #(.TMO_W(24), .TMO_CYC(24'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .clr_ID_vld (clr_ID_vld),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .go         (go),
    .arrived    (arrived),
    .tmo        (tmo),
    .stn_cnt    (stn_cnt),
    .last_ID    (last_ID),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int id_pulses = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps its mode as an int. Timing is tracked as an absolute deadline
  // in edge numbers. Time spent in ACK pushes the deadline out.
  int         m_mode;        // 0 idle, 1 navigating, 2 acknowledging
  int         m_now;
  int         m_deadline;
  int         m_dest;
  int         m_cnt;
  int         m_last;
  bit         m_go, m_arr, m_tmo, m_clr_id, m_clr_cmd, m_busy, m_home;
  logic [16:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_now = 0; m_deadline = 0; m_dest = 0; m_cnt = 0; m_last = 0;
    m_go = 0; m_arr = 0; m_tmo = 0; m_clr_id = 0; m_clr_cmd = 0; m_busy = 0; m_home = 0;
    exp_q.delete();
  endtask

  function automatic logic [16:0] model_vec();
    return {2'(m_mode), m_go, m_arr, m_tmo, 4'(m_cnt), 6'(m_last), m_clr_id, m_clr_cmd};
  endfunction

  // Called with the inputs that the next rising edge will sample.
  task automatic model_step();
    bit       take;
    int       op;
    bit       hit;
    bit       dup;
    m_now++;
    m_arr = 0; m_clr_id = 0; m_clr_cmd = 0;
    op   = int'(cmd[7:6]);
    take = cmd_rdy && !m_busy && (m_mode != 2);
    if (!cmd_rdy) m_busy = 0;
    else if (take) m_busy = 1;
    hit = (int'(ID[5:0]) == m_dest);
`ifdef DUP_FILTER_EN
    dup = (int'(ID[5:0]) == m_last);
`else
    dup = 0;
`endif
    if (m_mode == 0) begin
      if (take) begin
        m_clr_cmd = 1;
        if (op == 1) begin
          m_dest = int'(cmd[5:0]); m_cnt = 0; m_tmo = 0; m_go = 1; m_mode = 1;
          m_deadline = m_now + TMO;
        end
      end else if (ID_vld) begin
        m_clr_id = 1; m_home = 1; m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (take) begin
        m_clr_cmd = 1;
        if (op == 0) begin
          m_go = 0; m_mode = 0;
        end else if (op == 1) begin
          m_dest = int'(cmd[5:0]); m_cnt = 0; m_deadline = m_now + TMO;
        end
      end else if (ID_vld) begin
        m_clr_id = 1; m_mode = 2;
        if (ID[7:6] == 2'b00) begin
          m_last = int'(ID[5:0]);
          if (hit) begin
            m_arr = 1; m_go = 0; m_home = 1;
          end else if (!dup) begin
            m_deadline = m_now + TMO;
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
          end
        end
      end else if (m_now >= m_deadline) begin
        m_tmo = 1; m_go = 0; m_mode = 0;
      end
    end else begin
      m_deadline++;
      if (!ID_vld) begin
        m_mode = m_home ? 0 : 1;
        m_home = 0;
      end
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic check_vec(input string pfx, input logic [16:0] e);
    check({pfx, "_state"},   state_dbg,   e[16:15]);
    check({pfx, "_go"},      go,          e[14]);
    check({pfx, "_arrived"}, arrived,     e[13]);
    check({pfx, "_tmo"},     tmo,         e[12]);
    check({pfx, "_stn_cnt"}, stn_cnt,     e[11:8]);
    check({pfx, "_last_ID"}, last_ID,     e[7:2]);
    check({pfx, "_clr_id"},  clr_ID_vld,  e[1]);
    check({pfx, "_clr_cmd"}, clr_cmd_rdy, e[0]);
  endtask

  // One clock: predict, clock, then compare #1 after the edge.
  task automatic cycle();
    logic [16:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (clr_ID_vld) id_pulses++;
    e = exp_q.pop_front();
    check_vec("cyc", e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ID_vld = 1'b0; cmd_rdy = 1'b0; ID = 8'h00; cmd = 8'h00;
    #1;
    model_reset();
    check_vec("rst", model_vec());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd = c; cmd_rdy = 1'b1;
    cycle();
    cmd_rdy = 1'b0;
    cycle();
  endtask

  task automatic send_id(input logic [7:0] i);
    ID = i; ID_vld = 1'b1;
    cycle();
    ID_vld = 1'b0;
    cycle();
  endtask

  // ---------------- randomized traffic ----------------
  task automatic rand_phase(input int ncyc, input int id_rate, input int cmd_rate);
    bit         id_acked = 0;
    bit         cmd_acked = 0;
    int         id_hold = 0;
    int         cmd_hold = 0;
    logic [1:0] top;
    logic [5:0] num;
    int         r;
    for (int k = 0; k < ncyc; k++) begin
      if (ID_vld) begin
        if (clr_ID_vld) id_acked = 1;
        if (id_acked) begin
          if (id_hold == 0) begin ID_vld = 1'b0; id_acked = 0; end
          else id_hold--;
        end
      end else if ($urandom_range(0, 99) < id_rate) begin
        r   = $urandom_range(0, 9);
        num = 6'($urandom_range(0, 7));
        top = (r < 8) ? 2'b00 : 2'($urandom_range(1, 3));
        ID = {top, num}; ID_vld = 1'b1; id_hold = $urandom_range(0, 4);
      end
      if (cmd_rdy) begin
        if (clr_cmd_rdy) cmd_acked = 1;
        if (cmd_acked) begin
          if (cmd_hold == 0) begin cmd_rdy = 1'b0; cmd_acked = 0; end
          else cmd_hold--;
        end
      end else if ($urandom_range(0, 99) < cmd_rate) begin
        r   = $urandom_range(0, 9);
        num = 6'($urandom_range(0, 7));
        top = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : 2'($urandom_range(2, 3));
        cmd = {top, num}; cmd_rdy = 1'b1; cmd_hold = $urandom_range(0, 3);
      end
      cycle();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p0;
    rst_n = 1'b0; ID = 8'h00; ID_vld = 1'b0; cmd = 8'h00; cmd_rdy = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Basic trip to station 5 via station 3
    cmd = 8'h45; cmd_rdy = 1'b1;
    cycle();
    check("t1_go", go, 1'b1);
    check("t1_clr_cmd", clr_cmd_rdy, 1'b1);
    cmd_rdy = 1'b0;
    cycle();
    check("t1_clr_cmd_single", clr_cmd_rdy, 1'b0);
    ID = 8'h03; ID_vld = 1'b1;
    cycle();
    check("t1_clr_id", clr_ID_vld, 1'b1);
    check("t1_cnt1", stn_cnt, 4'd1);
    ID_vld = 1'b0;
    cycle();
    check("t1_back_nav", state_dbg, ST_NAV);
    ID = 8'h05; ID_vld = 1'b1;
    cycle();
    check("t1_arrived", arrived, 1'b1);
    check("t1_go_low", go, 1'b0);
    check("t1_last", last_ID, 6'h05);
    ID_vld = 1'b0;
    cycle();
    check("t1_idle", state_dbg, ST_IDLE);
    check("t1_arr_pulse", arrived, 1'b0);

    // Invalid ID while navigating to 5
    send_cmd(8'h45);
    send_id(8'h03);
    ID = 8'hC5; ID_vld = 1'b1;
    cycle();
    check("t2_clr_id", clr_ID_vld, 1'b1);
    check("t2_no_arr", arrived, 1'b0);
    check("t2_cnt", stn_cnt, 4'd1);
    check("t2_last", last_ID, 6'h03);
    check("t2_go", go, 1'b1);
    ID_vld = 1'b0;
    cycle();
    send_cmd(8'h00);
    check("t2_stop", go, 1'b0);

    // Timeout after exactly TMO cycles
    cmd = 8'h41; cmd_rdy = 1'b1;
    cycle();
    cmd_rdy = 1'b0;
    for (int k = 0; k < TMO - 1; k++) cycle();
    check("t3_go_before", go, 1'b1);
    check("t3_tmo_before", tmo, 1'b0);
    cycle();
    check("t3_tmo", tmo, 1'b1);
    check("t3_go_after", go, 1'b0);
    cmd = 8'h41; cmd_rdy = 1'b1;
    cycle();
    check("t3_tmo_clr", tmo, 1'b0);
    cmd_rdy = 1'b0;
    cycle();

    // Stop and ID arriving together
    p0 = id_pulses;
    cmd = 8'h00; cmd_rdy = 1'b1; ID = 8'h02; ID_vld = 1'b1;
    cycle();
    check("t4_go", go, 1'b0);
    cmd_rdy = 1'b0;
    cycle();
    cycle();
    ID_vld = 1'b0;
    cycle();
    check("t4_pulses", id_pulses - p0, 1);
    check("t4_cnt", stn_cnt, 4'd0);

    // Saturation and repeated station
    send_cmd(8'h4F);
    send_id(8'h07);
    send_id(8'h07);
`ifdef DUP_FILTER_EN
    check("t5_dup", stn_cnt, 4'd1);
`else
    check("t5_dup", stn_cnt, 4'd2);
`endif
    send_cmd(8'h4F);
    for (int k = 0; k < 17; k++) send_id(8'(16 + k));
    check("t5_sat", stn_cnt, 4'hF);

    // ID held after acknowledge, then reset inside ACK
    p0 = id_pulses;
    ID = 8'h09; ID_vld = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) cycle();
    check("t6_pulses", id_pulses - p0, 1);
    check("t6_in_ack", state_dbg, ST_ACK);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_vec("t6_rst", model_vec());
    ID_vld = 1'b0; cmd_rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic: busy phase, then a sparse phase that reaches timeouts
    rand_phase(3000, 20, 5);
    rand_phase(2000, 1, 1);
    rand_phase(1500, 30, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
